// File: rtl/fifo_pkt_reader.sv
// Packet FIFO reader: fetches header/payload/parity bytes and streams them out with sop/eop.
// Define FIFO_PKT_READER_PARITY_CHK_EN to enable the parity accumulator and compare.
module fifo_pkt_reader #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic       pkt_err,
  output logic       soft_reset_out
);

  localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LEN_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_PLD   = 3'd2,
    S_PAR   = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_run;
  logic               r_inflight;
  logic [LEN_W-1:0]   r_cnt;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic [7:0]         r_out_data;
  logic               r_out_valid;
  logic               r_sop;
  logic               r_eop;
  logic               r_to_err;
  logic               r_soft;
`ifdef FIFO_PKT_READER_PARITY_CHK_EN
  logic [7:0]         r_acc;
  logic               r_par_bad;
`endif

  logic w_accept;
  logic w_fetch;
  logic w_wait;
  logic w_timeout;

  // Fetch is decided on live FIFO/ready status so an empty FIFO is never read.
  assign w_accept  = r_out_valid & out_ready;
  assign w_fetch   = r_run & ~fifo_empty & ~r_inflight & (~r_out_valid | out_ready)
                   & (r_state != S_ABORT);
  assign w_wait    = ((r_state == S_HDR) || (r_state == S_PLD) || (r_state == S_PAR))
                   & ~r_inflight;
  assign w_timeout = w_wait & fifo_empty & (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

  assign fifo_rd_en     = w_fetch;
  assign out_data       = r_out_data;
  assign out_valid      = r_out_valid;
  assign out_sop        = r_sop;
  assign out_eop        = r_eop;
  assign soft_reset_out = r_soft;
`ifdef FIFO_PKT_READER_PARITY_CHK_EN
  // Parity error must coincide with acceptance of the eop byte.
  assign pkt_err = r_to_err | (w_accept & r_eop & r_par_bad);
`else
  assign pkt_err = r_to_err;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_run       <= 1'b0;
      r_inflight  <= 1'b0;
      r_cnt       <= '0;
      r_idle_cnt  <= '0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_to_err    <= 1'b0;
      r_soft      <= 1'b0;
`ifdef FIFO_PKT_READER_PARITY_CHK_EN
      r_acc       <= 8'h00;
      r_par_bad   <= 1'b0;
`endif
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_fetch;
      r_to_err   <= 1'b0;
      r_soft     <= 1'b0;
      r_idle_cnt <= (w_wait && fifo_empty) ? r_idle_cnt + IDLE_W'(1) : '0;

      if (w_accept) begin
        r_out_valid <= 1'b0;
        r_sop       <= 1'b0;
        r_eop       <= 1'b0;
      end

      // A landing byte always finds the output register free or retiring.
      if (r_inflight) begin
        r_out_data  <= fifo_dout;
        r_out_valid <= 1'b1;
        r_sop       <= (r_state == S_HDR);
        r_eop       <= (r_state == S_PAR);
      end

      case (r_state)
        S_IDLE: begin
          if (w_fetch) r_state <= S_HDR;
        end
        S_HDR: begin
          if (r_inflight) begin
            r_cnt   <= fifo_dout[7:2];
            r_state <= (fifo_dout[7:2] == 6'd0) ? S_PAR : S_PLD;
`ifdef FIFO_PKT_READER_PARITY_CHK_EN
            r_acc   <= fifo_dout;
`endif
          end
        end
        S_PLD: begin
          if (r_inflight) begin
            r_cnt <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) r_state <= S_PAR;
`ifdef FIFO_PKT_READER_PARITY_CHK_EN
            r_acc <= r_acc ^ fifo_dout;
`endif
          end
        end
        S_PAR: begin
          if (r_inflight) begin
            r_state   <= S_IDLE;
`ifdef FIFO_PKT_READER_PARITY_CHK_EN
            r_par_bad <= (fifo_dout != r_acc);
`endif
          end
        end
        S_ABORT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Starved mid-packet: drop any pending byte and request a FIFO flush.
      if (w_timeout) begin
        r_state     <= S_ABORT;
        r_out_valid <= 1'b0;
        r_sop       <= 1'b0;
        r_eop       <= 1'b0;
        r_to_err    <= 1'b1;
        r_soft      <= 1'b1;
        r_idle_cnt  <= '0;
      end
    end
  end

endmodule

// File: doc/fifo_pkt_reader.md
FIFO_PKT_READER -- requirements
Module: fifo_pkt_reader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port fifo_empty, input, 1 bit: packet FIFO holds no byte.
REQ-004 SHALL have port fifo_dout, input, 8 bits: FIFO read data, valid in the cycle after a cycle with fifo_rd_en=1.
REQ-005 SHALL have port fifo_rd_en, output, 1 bit: FIFO read strobe.
REQ-006 SHALL have port out_data, output, 8 bits: downstream byte.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts when out_valid and out_ready are both 1.
REQ-009 SHALL have port out_sop, output, 1 bit: out_data is a header byte.
REQ-010 SHALL have port out_eop, output, 1 bit: out_data is the parity byte.
REQ-011 SHALL have port pkt_err, output, 1 bit: one-cycle pulse for a parity mismatch or a timeout.
REQ-012 SHALL have port soft_reset_out, output, 1 bit: one-cycle pulse requesting a FIFO flush on timeout.
REQ-013 SHALL have parameter TIMEOUT, default 30: maximum number of consecutive mid-packet empty cycles.

Function
REQ-014 Packet format SHALL be:
- header = {len[5:0], addr[1:0]}
- then len payload bytes (len 0..63)
- then one parity byte = XOR of header and all payload bytes.
REQ-015 FSM states SHALL be IDLE, HDR, PLD, PAR, ABORT.
REQ-016 Fetch rule: fifo_rd_en=1 only when all of the following hold:
- fifo_empty=0;
- no fetch is in flight;
- out_valid=0, or (out_valid=1 and out_ready=1);
- state is not ABORT.
REQ-017 Read latency: fifo_rd_en at cycle t SHALL give out_valid=1 in cycle t+2 with that byte; peak throughput is one byte per 2 cycles.
REQ-018 IDLE->HDR on the first fetch; the header byte SHALL load the 6-bit down-counter with len and the parity accumulator with the header value.
REQ-019 HDR->PLD after header load if len!=0; HDR->PAR if len=0.
REQ-020 PLD: each loaded byte SHALL decrement the counter and XOR into the accumulator; PLD->PAR when the counter reaches 0.
REQ-021 PAR: the loaded byte SHALL be presented with out_eop=1; the FSM SHALL go to IDLE when the byte is loaded.
REQ-022 out_sop and out_eop SHALL be 1 only while out_valid=1.
REQ-023 out_data, out_sop and out_eop SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 Parity compare: pkt_err SHALL pulse in the cycle the parity byte is accepted if the byte differs from the accumulator.
REQ-025 Timeout: in HDR/PLD/PAR with no fetch in flight, an idle counter SHALL count consecutive fifo_empty=1 cycles and clear on any fetch.
REQ-026 When the idle counter reaches TIMEOUT, the FSM SHALL go to ABORT and pulse pkt_err and soft_reset_out for one cycle each.
REQ-027 On entering ABORT, any pending out_valid byte SHALL be dropped; ABORT->IDLE the next cycle.
REQ-028 IDLE with fifo_empty=1 SHALL never time out.
REQ-029 If out_ready=1 and a fetched byte lands in the same cycle, the old byte SHALL be retired and the new byte loaded; no byte is lost or duplicated.

Reset
REQ-030 While resetn=0 the block SHALL hold:
- state=IDLE;
- counter, accumulator and idle counter = 0;
- fifo_rd_en, out_valid, out_sop, out_eop, pkt_err, soft_reset_out = 0;
- out_data=8'h00.
REQ-031 Reset mid-packet SHALL abandon the packet with no pkt_err and no soft_reset_out; after release, the next byte read is treated as a header.

Configuration
REQ-032 Macro FIFO_PKT_READER_PARITY_CHK_EN defined: parity accumulator and compare (REQ-024) SHALL be present.
REQ-033 Macro FIFO_PKT_READER_PARITY_CHK_EN undefined:
- no accumulator and no compare;
- the parity byte is still forwarded with out_eop;
- pkt_err pulses only on timeout.

Verification
REQ-034 Header 8'h39 (len 14, addr 01), payload 0..13, correct parity, out_ready=1 -> 16 bytes out, sop on the first byte, eop on the last, pkt_err never asserts.
REQ-035 Same packet with parity byte inverted -> pkt_err pulses exactly once, in the cycle the eop byte is accepted (macro defined); no pulse with the macro undefined.
REQ-036 Header 8'h02 (len 0) followed by parity 8'h02 -> 2 bytes out; the second has out_eop=1; no error.
REQ-037 out_ready held 0 for 10 cycles mid-payload -> out_data stable, fifo_rd_en=0 throughout, byte order preserved after release.
REQ-038 Header plus 3 payload bytes, then fifo_empty=1 for 30 cycles -> pkt_err and soft_reset_out pulse together once; state returns to IDLE; the next packet is read correctly.
REQ-039 resetn asserted mid-payload -> all outputs 0 asynchronously; after release, a new full packet passes with no error.
